pc_fetch: RTL
=============

# pc_fetch

Instruction-fetch front end: owns the architectural fetch PC and drives the instruction-memory request/response handshake. It presents fetched instructions to the ID stage. Each cycle it exports `pc_now` to the next-PC block and consumes the `npc` that block returns, taking it on sequential advance or on an EX-stage redirect. It tracks one outstanding memory request, discards responses made stale by a redirect, and flags misaligned fetch targets.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC loaded on reset.
- `NOP_INST`, default 32'h0000_0013, instruction word presented with a misaligned-fetch exception.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `npc`  in  32  next PC from the next-PC block, valid combinationally every cycle.
- `redirect`  in  1  EX resolved a non-sequential flow (jal/jalr/branch path); `npc` holds the new target.
- `pc_now`  out  32  current fetch PC, registered.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, always equal to `pc_now`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid, earliest one cycle after `imem_gnt`.
- `imem_rdata`  in  32  response instruction word.
- `if_valid`  out  1  instruction available to ID.
- `if_pc`  out  32  PC of the presented instruction, equal to `pc_now`.
- `if_inst`  out  32  presented instruction word, registered.
- `if_exc`  out  1  presented slot is a misaligned-fetch exception.
- `id_ready`  in  1  ID consumes the presented instruction this cycle.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Internal `kill` flag marks the in-flight response as stale.
- Decode: `imem_req` = (state==REQ) && `pc_now[1:0]`==0. `if_valid` = (state==HOLD).
- IDLE: entered only from reset. Next state is REQ unconditionally.
- REQ, with `pc_now[1:0]`!=0: no request. Load `if_inst`<=`NOP_INST` and `if_exc`<=1, then go to HOLD. `redirect` takes priority: `pc_now`<=`npc`, stay in REQ.
- REQ, aligned:
  - `imem_gnt`&&!`redirect`: go to WAIT with `kill`=0.
  - `imem_gnt`&&`redirect`: `pc_now`<=`npc`, go to WAIT with `kill`=1.
  - !`imem_gnt`&&`redirect`: `pc_now`<=`npc`, stay in REQ. The address changes only in this case while a request is unacknowledged.
  - Otherwise hold.
- WAIT:
  - `imem_rvalid` with `kill`||`redirect`: discard the data, clear `kill`, go to REQ. If `redirect`, also `pc_now`<=`npc`.
  - `imem_rvalid` clean: `if_inst`<=`imem_rdata`, `if_exc`<=0, go to HOLD.
  - `redirect` without `imem_rvalid`: `pc_now`<=`npc`, `kill`<=1, stay in WAIT.
- HOLD:
  - `redirect`: `pc_now`<=`npc`, drop the slot, go to REQ. Redirect has priority over `id_ready`.
  - `id_ready`: `pc_now`<=`npc`, go to REQ. The next-PC block supplies `npc` = `pc_now`+4 here.
  - Otherwise hold. `if_inst`, `if_pc` and `if_exc` remain stable.
- `npc` is sampled only on advance or redirect. Values at other times are ignored.
- PC arithmetic is performed upstream. This block performs no addition and has no wrap handling; 32'hFFFF_FFFC+4 arrives as 0 and is fetched normally.

## Timing
- Reset (`rst_n`=0 at an edge): state<=IDLE, `pc_now`<=`RESET_PC`, `kill`<=0, `if_inst`<=0, `if_exc`<=0.
  - Outputs during reset: `imem_req`=0, `if_valid`=0.
- First edge with `rst_n`=1: IDLE->REQ. `imem_req` rises in the second cycle after release.
- Reset asserted mid-operation aborts everything. A response arriving after reset, while in IDLE or REQ, is ignored: `imem_rvalid` is only observed in WAIT.
- Best-case throughput, with `imem_gnt` in the request cycle and `imem_rvalid` one cycle later:
  - REQ at cycle t, WAIT at t+1, HOLD at t+2.
  - With `id_ready`=1, REQ for `pc_now`+4 at t+3.
  - One instruction per 3 cycles.
- At most one request is outstanding. `imem_req` is never asserted in WAIT or HOLD.
- Redirect latency: the new PC appears on `pc_now`/`imem_addr` the cycle after `redirect`. It appears no later than the cycle after any stale response drains.

## Test plan
- Reset, `RESET_PC`=32'h8000_0000, `rst_n` low for 3 cycles:
  - During reset: `imem_req`=0, `if_valid`=0, `pc_now`=32'h8000_0000.
  - Release: IDLE for 1 cycle, then `imem_req`=1 with `imem_addr`=32'h8000_0000.
- Sequential fetch, gnt immediate, `imem_rdata`=32'h0050_0093 one cycle later, `id_ready`=1, `npc`=pc+4:
  - `if_valid` for exactly 1 cycle with `if_inst`=32'h0050_0093 and `if_pc`=32'h8000_0000.
  - Next `imem_req` at `imem_addr`=32'h8000_0004, 3 cycles after the first request.
- Redirect in WAIT: `redirect`=1 with `npc`=32'h8000_0100 two cycles before `imem_rvalid` (rdata 32'hDEAD_BEEF):
  - The response is never presented (`if_valid` stays 0).
  - Next request goes to 32'h8000_0100.
- Redirect in the same cycle as `imem_gnt`, target 32'h8000_0200:
  - The following response is dropped.
  - The next request goes to 32'h8000_0200, and that response is presented with `if_pc`=32'h8000_0200.
- Stall then redirect: `id_ready`=0 for 4 cycles in HOLD, then `redirect` with `id_ready`=1:
  - While stalled: `if_inst`/`if_pc` stable and `imem_req`=0.
  - On redirect: the slot is dropped and `pc_now` takes `npc`, not the sequential address.
- Misaligned redirect to 32'h8000_0102:
  - `imem_req` stays 0.
  - `if_valid`=1, `if_exc`=1, `if_inst`=32'h0000_0013, `if_pc`=32'h8000_0102.
  - Held until `id_ready`.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: fetch PC owner and single-outstanding instruction-memory handshake feeding ID
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        redirect,
  output logic [31:0] pc_now,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_exc,
  input  logic        id_ready
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state;
  logic   kill;
  assign imem_req  = (state == REQ) && (pc_now[1:0] == 2'b00);
  assign imem_addr = pc_now;
  assign if_valid  = (state == HOLD);
  assign if_pc     = pc_now;
  // fetch sequencing; kill marks the in-flight response as stale after a redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_now  <= RESET_PC;
      kill    <= 1'b0;
      if_inst <= '0;
      if_exc  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:
          if (redirect) begin
            pc_now <= npc;
            if (imem_req && imem_gnt) begin
              state <= WAIT;
              kill  <= 1'b1;
            end
          end else if (pc_now[1:0] != 2'b00) begin
            if_inst <= NOP_INST;
            if_exc  <= 1'b1;
            state   <= HOLD;
          end else if (imem_gnt) begin
            state <= WAIT;
            kill  <= 1'b0;
          end
        WAIT:
          if (imem_rvalid) begin
            if (kill || redirect) begin
              kill  <= 1'b0;
              state <= REQ;
              if (redirect) pc_now <= npc;
            end else begin
              if_inst <= imem_rdata;
              if_exc  <= 1'b0;
              state   <= HOLD;
            end
          end else if (redirect) begin
            pc_now <= npc;
            kill   <= 1'b1;
          end
        HOLD:
          if (redirect || id_ready) begin
            pc_now <= npc;
            state  <= REQ;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
